// File: rtl/stream_demux_pkg.sv
// Shared types and constants for the stream_demux 1:2 stream router.
// Optional per-output delivery counters are enabled with STREAM_DEMUX_STATS_EN.
package stream_demux_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } buf_state_t;

    localparam int DEMUX_BUF_DEPTH = 2;
    localparam int STATS_CNT_W     = 16;

endpackage

// File: rtl/demux_skid_buf.sv
// Two-entry FIFO buffer for one demux output. Slot 0 always holds the head,
// so the output payload comes straight from a register.
module demux_skid_buf
    import stream_demux_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic              valid,
    output logic              full,
    output logic [DATA_W-1:0] head_data
);

    buf_state_t        state_reg;
    buf_state_t        state_next;
    logic [DATA_W-1:0] mem_reg  [DEMUX_BUF_DEPTH];
    logic [DATA_W-1:0] mem_next [DEMUX_BUF_DEPTH];

    always_comb begin
        state_next = state_reg;
        for (int i = 0; i < DEMUX_BUF_DEPTH; i++) begin
            mem_next[i] = mem_reg[i];
        end
        case (state_reg)
            EMPTY: begin
                if (push) begin
                    state_next  = ONE;
                    mem_next[0] = push_data;
                end
            end
            ONE: begin
                if (push && !pop) begin
                    state_next  = TWO;
                    mem_next[1] = push_data;
                end else if (!push && pop) begin
                    state_next = EMPTY;
                end else if (push && pop) begin
                    // Head leaves while the new beat arrives: new beat becomes head.
                    mem_next[0] = push_data;
                end
            end
            TWO: begin
                // Pushes cannot arrive here because the top holds in_ready low.
                if (pop) begin
                    state_next  = ONE;
                    mem_next[0] = mem_reg[1];
                end
            end
            default: begin
                state_next = EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= EMPTY;
            for (int i = 0; i < DEMUX_BUF_DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
        end else begin
            state_reg <= state_next;
            for (int i = 0; i < DEMUX_BUF_DEPTH; i++) begin
                mem_reg[i] <= mem_next[i];
            end
        end
    end

    assign valid     = (state_reg != EMPTY);
    assign full      = (state_reg == TWO);
    assign head_data = mem_reg[0];

endmodule

// File: rtl/stream_demux.sv
// Routes one valid/ready stream to out0 or out1 per beat, each through its own
// two-entry buffer. Define STREAM_DEMUX_STATS_EN to add per-output pop counters.
module stream_demux
    import stream_demux_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sel,
    input  logic [DATA_W-1:0] in_data,
    output logic              out0_valid,
    input  logic              out0_ready,
    output logic [DATA_W-1:0] out0_data,
    output logic              out1_valid,
    input  logic              out1_ready,
    output logic [DATA_W-1:0] out1_data
`ifdef STREAM_DEMUX_STATS_EN
    ,
    output logic [STATS_CNT_W-1:0] out0_cnt,
    output logic [STATS_CNT_W-1:0] out1_cnt
`endif
);

    logic [1:0]        buf_valid;
    logic [1:0]        buf_full;
    logic [1:0]        buf_push;
    logic [1:0]        buf_pop;
    logic [1:0]        out_ready_vec;
    logic [DATA_W-1:0] buf_data [2];

    assign out_ready_vec = {out1_ready, out0_ready};

    // Depends only on the selected buffer's fill, never on downstream ready.
    assign in_ready = !buf_full[in_sel];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_buf
            assign buf_push[gi] = in_valid && in_ready && (in_sel == 1'(gi));
            assign buf_pop[gi]  = buf_valid[gi] && out_ready_vec[gi];

            demux_skid_buf #(
                .DATA_W(DATA_W)
            ) u_buf (
                .clk       (clk),
                .rst_n     (rst_n),
                .push      (buf_push[gi]),
                .push_data (in_data),
                .pop       (buf_pop[gi]),
                .valid     (buf_valid[gi]),
                .full      (buf_full[gi]),
                .head_data (buf_data[gi])
            );
        end
    endgenerate

    assign out0_valid = buf_valid[0];
    assign out0_data  = buf_data[0];
    assign out1_valid = buf_valid[1];
    assign out1_data  = buf_data[1];

`ifdef STREAM_DEMUX_STATS_EN
    logic [STATS_CNT_W-1:0] cnt_reg [2];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
            // Free-running count of delivered beats; wraps naturally.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    cnt_reg[gi] <= '0;
                end else if (buf_pop[gi]) begin
                    cnt_reg[gi] <= cnt_reg[gi] + STATS_CNT_W'(1);
                end
            end
        end
    endgenerate

    assign out0_cnt = cnt_reg[0];
    assign out1_cnt = cnt_reg[1];
`endif

endmodule

// File: tb/tb_stream_demux.sv
// Self-checking bench for stream_demux: directed scenarios plus a randomized run
// checked against a queue-based reference model of the two output buffers.
module tb_stream_demux;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic       in_sel;
    logic [7:0] in_data;
    logic       out0_valid;
    logic       out0_ready;
    logic [7:0] out0_data;
    logic       out1_valid;
    logic       out1_ready;
    logic [7:0] out1_data;

    int vectors = 0;
    int errors  = 0;

    // Reference model: each output is a FIFO of at most two accepted beats.
    logic [7:0] q0[$];
    logic [7:0] q1[$];

    stream_demux #(.DATA_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sel     (in_sel),
        .in_data    (in_data),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out0_data  (out0_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .out1_data  (out1_data)
    );

    always #5 clk = ~clk;

    function automatic bit model_ready(input logic sel);
        return sel ? (q1.size() < 2) : (q0.size() < 2);
    endfunction

    // Advance one clock edge and update the model from the inputs seen at that edge.
    task automatic tick();
        bit acc;
        bit pop0;
        bit pop1;
        @(posedge clk);
        if (!rst_n) begin
            q0.delete();
            q1.delete();
        end else begin
            acc  = in_valid && model_ready(in_sel);
            pop0 = (q0.size() > 0) && out0_ready;
            pop1 = (q1.size() > 0) && out1_ready;
            if (pop0) void'(q0.pop_front());
            if (pop1) void'(q1.pop_front());
            if (acc) begin
                if (in_sel) q1.push_back(in_data);
                else        q0.push_back(in_data);
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b1; in_sel = 1'($urandom); in_data = 8'($urandom);
        out0_ready = 1'b1; out1_ready = 1'b1;
        tick();
        tick();
        @(negedge clk);
        vectors++;
        if (out0_valid !== 1'b0 || out1_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid: got out0_valid=%b out1_valid=%b, want 0 0", out0_valid, out1_valid);
        end
        vectors++;
        if (out0_data !== 8'h00 || out1_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_data: got out0_data=%h out1_data=%h, want 00 00", out0_data, out1_data);
        end
        $display("reset: out0_valid=%b out1_valid=%b", out0_valid, out1_valid);
        rst_n = 1'b1; in_valid = 1'b0;
        tick();
    endtask

    task automatic test_single_route();
        in_valid = 1'b1; in_sel = 1'b0; in_data = 8'hA5;
        @(negedge clk);
        vectors++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL route_ready0: got in_ready=%b, want 1", in_ready);
        end
        tick();
        in_sel = 1'b1; in_data = 8'h3C;
        @(negedge clk);
        vectors++;
        if (out0_valid !== 1'b1 || out0_data !== 8'hA5) begin
            errors++;
            $display("FAIL route_out0: got valid=%b data=%h, want 1 a5", out0_valid, out0_data);
        end
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if (out1_valid !== 1'b1 || out1_data !== 8'h3C || out0_valid !== 1'b0) begin
            errors++;
            $display("FAIL route_out1: got out1 valid=%b data=%h out0_valid=%b, want 1 3c 0",
                     out1_valid, out1_data, out0_valid);
        end
        $display("single_route: out0=a5 out1=%h", out1_data);
        tick();
    endtask

    task automatic test_back_pressure();
        logic [7:0] obs[$];
        logic [7:0] want[3];
        bit         acc;
        want[0] = 8'h01; want[1] = 8'h02; want[2] = 8'h03;
        out0_ready = 1'b0; out1_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_sel = 1'b0; in_data = want[i];
            @(negedge clk);
            vectors++;
            if (in_ready !== (i < 2)) begin
                errors++;
                $display("FAIL bp_ready_%0d: got in_ready=%b, want %b", i, in_ready, (i < 2));
            end
            tick();
        end
        in_sel = 1'b1; in_data = 8'h77;
        @(negedge clk);
        vectors++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_other_ready: got in_ready=%b, want 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if (out1_valid !== 1'b1 || out1_data !== 8'h77) begin
            errors++;
            $display("FAIL bp_other_out: got valid=%b data=%h, want 1 77", out1_valid, out1_data);
        end
        tick();
        // Release out0 and keep offering 0x03 until it is accepted.
        in_valid = 1'b1; in_sel = 1'b0; in_data = 8'h03; out0_ready = 1'b1;
        for (int cyc = 0; cyc < 20 && obs.size() < 3; cyc++) begin
            @(negedge clk);
            if (out0_valid && out0_ready) obs.push_back(out0_data);
            acc = in_valid && model_ready(1'b0);
            tick();
            if (acc) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        vectors++;
        if (obs.size() != 3) begin
            errors++;
            $display("FAIL bp_drain_count: got %0d beats, want 3", obs.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                vectors++;
                if (obs[i] !== want[i]) begin
                    errors++;
                    $display("FAIL bp_order_%0d: got %h, want %h", i, obs[i], want[i]);
                end
            end
        end
        $display("back_pressure: drained %0d beats on out0", obs.size());
    endtask

    task automatic test_full_throughput();
        logic [7:0] exp0[$];
        logic [7:0] exp1[$];
        logic [7:0] obs0[$];
        logic [7:0] obs1[$];
        out0_ready = 1'b1; out1_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_valid = (i < 16);
            in_sel   = 1'(i % 2);
            in_data  = 8'($urandom);
            if (in_valid) begin
                if (in_sel) exp1.push_back(in_data);
                else        exp0.push_back(in_data);
            end
            @(negedge clk);
            if (i < 16) begin
                vectors++;
                if (in_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL thru_ready_%0d: got in_ready=%b, want 1", i, in_ready);
                end
            end
            if (out0_valid) obs0.push_back(out0_data);
            if (out1_valid) obs1.push_back(out1_data);
            tick();
        end
        in_valid = 1'b0;
        vectors++;
        if (obs0.size() != 8 || obs1.size() != 8) begin
            errors++;
            $display("FAIL thru_count: got out0=%0d out1=%0d beats, want 8 8", obs0.size(), obs1.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                vectors++;
                if (obs0[i] !== exp0[i] || obs1[i] !== exp1[i]) begin
                    errors++;
                    $display("FAIL thru_order_%0d: got %h/%h, want %h/%h", i, obs0[i], obs1[i], exp0[i], exp1[i]);
                end
            end
        end
        $display("full_throughput: out0=%0d out1=%0d beats", obs0.size(), obs1.size());
    endtask

    task automatic test_random();
        int bad = 0;
        for (int i = 0; i < 400; i++) begin
            in_valid   = ($urandom_range(0, 9) < 7);
            in_sel     = 1'($urandom);
            in_data    = 8'($urandom);
            out0_ready = ($urandom_range(0, 9) < 6);
            out1_ready = ($urandom_range(0, 9) < 6);
            @(negedge clk);
            vectors++;
            if (in_ready !== model_ready(in_sel)
                || out0_valid !== (q0.size() > 0) || out1_valid !== (q1.size() > 0)
                || (q0.size() > 0 && out0_data !== q0[0])
                || (q1.size() > 0 && out1_data !== q1[0])) begin
                errors++;
                bad++;
                $display("FAIL random_%0d: got rdy=%b v0=%b d0=%h v1=%b d1=%h, want rdy=%b depth0=%0d depth1=%0d",
                         i, in_ready, out0_valid, out0_data, out1_valid, out1_data,
                         model_ready(in_sel), q0.size(), q1.size());
            end
            tick();
        end
        in_valid = 1'b0;
        $display("random: 400 cycles, %0d bad", bad);
    endtask

    task automatic test_reset_mid();
        in_valid = 1'b0; out0_ready = 1'b1; out1_ready = 1'b1;
        repeat (3) tick();
        out1_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_sel = 1'b1; in_data = 8'hC0 + 8'(i);
            @(negedge clk);
            vectors++;
            if (in_ready !== (i < 2)) begin
                errors++;
                $display("FAIL mid_fill_%0d: got in_ready=%b, want %b", i, in_ready, (i < 2));
            end
            tick();
        end
        rst_n = 1'b0; out1_ready = 1'b1;
        tick();
        rst_n = 1'b1; in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if (out1_valid !== 1'b0 || out1_data !== 8'h00) begin
                errors++;
                $display("FAIL mid_reset_%0d: got valid=%b data=%h, want 0 00", i, out1_valid, out1_data);
            end
            tick();
        end
        $display("reset_mid: out1_valid=%b after reset", out1_valid);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_sel = 1'b0; in_data = 8'h00;
        out0_ready = 1'b0; out1_ready = 1'b0;
        test_reset();
        test_single_route();
        test_back_pressure();
        test_full_throughput();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
